// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  // Width in bits of one bus beat carrying dma words of 32 bits.
  function automatic int unsigned mem_beat_width(input int unsigned dma);
    return dma * 32;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port synchronous beat RAM with registered read; no reset so it maps to block RAM.
module mem_responder_array #(
  parameter int unsigned width_p = 128,
  parameter int unsigned depth_p = 256
) (
  input  logic                       clk_i,
  input  logic                       en_i,
  input  logic                       we_i,
  input  logic [$clog2(depth_p)-1:0] addr_i,
  input  logic [width_p-1:0]         wdata_i,
  output logic [width_p-1:0]         rdata_o
);

  logic [width_p-1:0] mem_q [depth_p];
  logic [width_p-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency main-memory responder: one single-beat read or write in flight at a time.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned dma_data_width_p = 4,
  parameter int unsigned mem_words_p      = 4096,
  parameter int unsigned latency_p        = 4
) (
  input  logic                            clk_i,
  input  logic                            nreset_i,
  input  logic                            mem_valid_i,
  output logic                            mem_ready_o,
  input  logic                            mem_we_i,
  input  logic [31:0]                     mem_addr_i,
  input  logic [dma_data_width_p*32-1:0]  mem_wdata_i,
  output logic                            mem_valid_o,
  output logic [dma_data_width_p*32-1:0]  mem_data_o
);

  localparam int unsigned BeatW = mem_beat_width(dma_data_width_p);
  localparam int unsigned BOff  = $clog2(dma_data_width_p * 4);
  localparam int unsigned Depth = mem_words_p / dma_data_width_p;
  localparam int unsigned IdxW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(latency_p + 1);

  mem_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [BeatW-1:0] wdata_q, wdata_d;
  logic             valid_q, valid_d;
  logic             seen_q, seen_d;
  logic             accept;
  logic             fire;
  logic [BeatW-1:0] rdata;
  logic             unused_addr;

  // Offset and wrap bits of the address are deliberately dropped.
  assign unused_addr = ^mem_addr_i;

  assign mem_ready_o = (state_q == MEM_IDLE) & nreset_i;
  assign accept      = mem_valid_i & mem_ready_o;
  assign fire        = (state_q == MEM_WAIT) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    seen_d  = seen_q;
    unique case (state_q)
      MEM_IDLE: begin
        if (accept) begin
          state_d = MEM_WAIT;
          cnt_d   = CntW'(latency_p - 1);
          we_d    = mem_we_i;
          idx_d   = mem_addr_i[BOff +: IdxW];
          wdata_d = mem_wdata_i;
        end
      end
      MEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d = we_q ? MEM_IDLE : MEM_RESP;
          valid_d = ~we_q;
          seen_d  = seen_q | ~we_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      MEM_RESP: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      seen_q  <= seen_d;
    end
  end

  mem_responder_array #(
    .width_p (BeatW),
    .depth_p (Depth)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (fire),
    .we_i    (we_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  // RAM read register has no reset; hide it until the first read response.
  assign mem_valid_o = valid_q;
  assign mem_data_o  = seen_q ? rdata : '0;

endmodule

// File: doc/mem_responder.md
# mem_responder

Behavioral-synthesizable main-memory responder for the memory side of the memsys bus-to-memory interface. It accepts one single-beat read or write request at a time from the bus's memory master port and stores `dma_data_width_p` 32-bit words per beat. After a fixed programmable latency it commits writes, or returns read data as a one-cycle pulse. It closes the loop for `memsys_top` in simulation and FPGA builds: each `mem_*_o` output of the bus connects to the matching `mem_*_i` input here, and vice versa.

## Interface
- `dma_data_width_p`, default 4: words per beat; must match the bus instance.
- `mem_words_p`, default 4096: total 32-bit words stored; must be a power of two and a multiple of `dma_data_width_p`.
- `latency_p`, default 4: wait cycles between acceptance and commit or response; must be at least 1.
- `clk_i`  in  1  clock; the only clock.
- `nreset_i`  in  1  reset; asynchronous, active-low.
- `mem_valid_i`  in  1  request valid.
- `mem_ready_o`  out  1  responder can accept a request.
- `mem_we_i`  in  1  1 = write beat, 0 = read beat.
- `mem_addr_i`  in  32  byte address.
- `mem_wdata_i`  in  `dma_data_width_p*32`  write beat; word 0 is in bits [31:0].
- `mem_valid_o`  out  1  read-response pulse; there is no backpressure.
- `mem_data_o`  out  `dma_data_width_p*32`  read beat.

## Operation
- Beat index: `idx = mem_addr_i[boff +: iw]`.
  - `boff = $clog2(dma_data_width_p*4)`.
  - `iw = $clog2(mem_words_p/dma_data_width_p)`.
  - Bits below `boff` are ignored, so unaligned addresses read or write the enclosing beat.
  - Bits above `boff+iw` are ignored, so addresses wrap.
- Acceptance happens on a rising edge where `mem_valid_i && mem_ready_o`. At that edge the block latches `we`, `idx` and `wdata`.
- FSM states are IDLE, WAIT and RESP.
  - **IDLE:** `mem_ready_o`=1. On accept, go to WAIT and set `cnt = latency_p-1`.
  - **WAIT:** `mem_ready_o`=0. Decrement `cnt` each cycle. When `cnt==0`:
    - Write: write `wdata` to `array[idx]` at the edge, then go to IDLE.
    - Read: load `mem_data_o <= array[idx]`, then go to RESP.
  - **RESP:** `mem_ready_o`=0 and `mem_valid_o`=1 for exactly one cycle, then go to IDLE.
- Request inputs are ignored outside the accept edge. The bus is free to change them while WAIT or RESP is in progress.
- `mem_data_o` holds the last read beat until the next read response loads it.
- Memory contents are not reset. A write is visible to any read accepted after that write's commit edge.
- `cnt` width is `$clog2(latency_p+1)`.

## Timing
- Number cycles relative to the accept edge: cycle 1 is the first cycle after it.
- Read with latency L:
  - WAIT in cycles 1..L.
  - `mem_valid_o` high in cycle L+1 only.
  - `mem_ready_o` high again from cycle L+2.
- Write with latency L:
  - WAIT in cycles 1..L.
  - Commit at the edge ending cycle L.
  - `mem_ready_o` high from cycle L+1.
- Peak throughput is one read per L+2 cycles or one write per L+1 cycles.
- A `mem_valid_i` held high during WAIT or RESP is not accepted until IDLE.
- Reset values:
  - `mem_ready_o`=0 while `nreset_i` is low. Implement as `(state==IDLE) & nreset_i`, so it is 1 from the first cycle after deassertion.
  - `mem_valid_o`=0.
  - `mem_data_o`=0.
  - state = IDLE, `cnt` = 0.
- Reset mid-operation: return to IDLE immediately.
  - An in-flight write is dropped and the array is unchanged.
  - A pending read response is never issued.

## Structure
- Add `mem_state_e` (IDLE, WAIT, RESP) to `cache.vh` next to `block_state_t`.
- Add a `` `mem_beat_width(dma) `` macro there.
- Natural sub-module: `mem_responder_array`, a single-port synchronous beat RAM with write enable and registered read. It maps to block RAM and has no reset.
- The top level holds the FSM, the latency counter and the request latches.

## Test plan
All cases use `dma_data_width_p`=4, `mem_words_p`=1024 and `latency_p`=3 unless stated.
1. Hold `nreset_i` low for 3 cycles, then release. Required:
   - `mem_ready_o`=0, `mem_valid_o`=0 and `mem_data_o`=0 during reset.
   - `mem_ready_o`=1 from the first cycle after release.
2. Write 0x40 with data {D,C,B,A}, then read 0x40. Required:
   - Write: ready low in cycles 1-3.
   - Read: `mem_valid_o` only in cycle 4 with data {D,C,B,A}; ready low in cycles 1-4.
3. Keep `mem_valid_i` high continuously with reads of 0x0, then 0x10. Required:
   - First accepted at edge 0; second accepted at the edge ending cycle 5.
   - Exactly two response pulses.
4. Wrap and alignment. Required:
   - Writing 0x1010 then reading 0x0010 returns the same beat.
   - Reading 0x4C returns the beat at 0x40.
5. Write 0x80 with data X after earlier data Y, then pulse `nreset_i` low during WAIT cycle 2. Required:
   - A subsequent read of 0x80 returns Y.
   - No `mem_valid_o` pulse from the aborted request.
6. Set `latency_p`=1 and read. Required: response in cycle 2, ready high again in cycle 3.
